// File: rtl/shift_pipe_if.sv
// Operand-in / result-out handshake bundle for the pipelined barrel shifter.
// Master drives operands and result acceptance; slave is the shifter.
interface shift_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [SW-1:0]    in_shamt;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_op, in_shamt, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_op, in_shamt, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROR), one shamt bit resolved per stage.
// Latency: SW register stages; result valid after the (SW-1)th edge following accept.
// Backpressure: whole pipe freezes while the output is stalled; in_ready = !out_valid || out_ready.
module shift_pipe #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    shift_pipe_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    logic             v_q  [SW];
    logic [1:0]       op_q [SW];
    logic [SW-1:0]    sh_q [SW];
    logic [WIDTH-1:0] d_q  [SW];

    logic             v_n  [SW];
    logic [1:0]       op_n [SW];
    logic [SW-1:0]    sh_n [SW];
    logic [WIDTH-1:0] d_n  [SW];

    logic en;

    // ASR needs no separate sign register: the MSB of a partially shifted
    // operand still equals the original sign, so replicating it stays correct.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] d,
        input int unsigned      amt
    );
        case (op)
            OP_LSL:  return d << amt;
            OP_LSR:  return d >> amt;
            OP_ASR:  return $signed(d) >>> amt;
            default: return (d >> amt) | (d << (WIDTH - amt));
        endcase
    endfunction

    assign en = !v_q[SW-1] || bus.out_ready;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        logic             v_i;
        logic [1:0]       op_i;
        logic [SW-1:0]    sh_i;
        logic [WIDTH-1:0] d_i;

        if (k == 0) begin : g_head
            assign v_i  = bus.in_valid;
            assign op_i = bus.in_op;
            assign sh_i = bus.in_shamt;
            assign d_i  = bus.in_data;
        end else begin : g_body
            assign v_i  = v_q[k-1];
            assign op_i = op_q[k-1];
            assign sh_i = sh_q[k-1];
            assign d_i  = d_q[k-1];
        end

        // Each stage consumes bit 0 of the shamt it receives and forwards the rest.
        assign v_n[k]  = v_i;
        assign op_n[k] = op_i;
        assign sh_n[k] = sh_i >> 1;
        assign d_n[k]  = sh_i[0] ? shift_by(op_i, d_i, 1 << k) : d_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SW; k++) begin
                v_q[k]  <= 1'b0;
                op_q[k] <= '0;
                sh_q[k] <= '0;
                d_q[k]  <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < SW; k++) begin
                v_q[k]  <= v_n[k];
                op_q[k] <= op_n[k];
                sh_q[k] <= sh_n[k];
                d_q[k]  <= d_n[k];
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[SW-1];
    assign bus.out_data  = d_q[SW-1];
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter with valid/ready flow control. It supports four operations on a WIDTH-bit operand: logical left, logical right, arithmetic right, and rotate right. The shift amount is resolved one shamt bit per registered stage, so one result per cycle is sustained at a fixed latency. It sits between the operand/register-read logic and the ALU result mux, and generalises the fixed 8-bit, 2-bit-shamt combinational shifters in the datapath.

## Interface
- WIDTH, 32, operand width; must be a power of two, ≥ 4.
- SW, $clog2(WIDTH), shamt width and pipeline stage count (derived; do not override).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_op  in  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_shamt  in  SW  shift amount, 0..WIDTH-1.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.

## Operation
- The pipeline has SW register stages. Stage k (k = 0..SW-1, LSB first) shifts by 2^k when shamt[k] = 1, and passes data through otherwise.
- Each stage register holds valid, op, the remaining shamt bits, and data. The last stage drives out_valid and out_data.
- Fill rules per stage:
  - LSL: zero-fill the low bits.
  - LSR: zero-fill the high bits.
  - ASR: replicate the original operand's bit WIDTH-1. The sign bit is carried with the data, so it is correct after partial shifts.
  - ROR: bits shifted out of bit 0 re-enter at bit WIDTH-1.
- Global enable: en = !out_valid || out_ready.
  - When en = 1, all stages advance one position.
  - When en = 0, every stage register holds its value.
- in_ready = en, a combinational function of out_valid and out_ready.
- Accept: an operand enters stage 0 on a rising edge with in_valid && in_ready.
  - If en = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed. Stall behaviour depends only on the output handshake.
- Results leave the block in acceptance order. Every accepted operand produces exactly one result; nothing is dropped or duplicated.
- in_op, in_shamt, and in_data are sampled only on acceptance.
- shamt = 0 returns in_data unchanged for all four ops.
- Reset:
  - On a rising edge with reset = 1, all stage valids clear to 0 and all data/op/shamt registers clear to 0.
  - In-flight operands are discarded and produce no output.
  - Reset overrides a simultaneous accept.

## Timing
- Reset values: out_valid = 0, out_data = 0.
- in_ready = 1 during the cycle following reset, because out_valid = 0.
- Latency: an operand accepted on edge N appears with out_valid = 1 after edge N+SW-1. It is consumed on the first later edge with out_ready = 1.
  - For WIDTH=8 (SW = 3), the result is visible in the cycle after the 3rd edge counted from the accept edge.
- Throughput: 1 result per cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, out_data is stable and in_ready = 0.
- Stall release: in the cycle where out_ready returns to 1, in_ready = 1. A new accept and the result consumption occur on the same edge.
- Output is held while stalled: out_valid must not drop without a handshake.
- No combinational path from in_* to out_*. The only combinational path is out_ready → in_ready.

## Test plan
- WIDTH=8, single op each, out_ready = 1, in_data = 0xB4, shamt = 3:
  - LSL → 0xA0
  - LSR → 0x16
  - ASR → 0xF6
  - ROR → 0x96
  - Each out_valid pulse arrives exactly SW = 3 cycles after accept.
- WIDTH=8, shamt = 0 and shamt = 7 on 0x81:
  - shamt = 0, all ops → 0x81
  - LSL 7 → 0x80
  - LSR 7 → 0x01
  - ASR 7 → 0xFF
  - ROR 7 → 0x03
- Back-to-back streaming: 16 random ops with in_valid and out_ready held at 1.
  - One result per cycle, in order, matching a software model; in_ready remains 1.
- Backpressure: out_ready = 0 for 5 cycles while in_valid = 1.
  - in_ready = 0 during the stall; out_data is stable.
  - No operand is lost or duplicated; order is preserved after release.
- Random valid/ready toggling for 2000 ops, WIDTH = 32 and WIDTH = 64:
  - Scoreboard matches every result; count in = count out.
- Reset mid-stream: assert reset with 3 operands in flight.
  - Next cycle: out_valid = 0, out_data = 0, in_ready = 1.
  - None of the flushed results ever appears.
